fetch_stage: RTL and testbench

//  Instruction fetch stage: owns the PC, issues one-outstanding read requests to instruction memory,
//  and buffers returned words in a small FIFO that feeds the decode stage with a valid/ready handshake.

---
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/fetch_stage_if.sv | 29 ++
 rtl/fetch_stage_fifo.sv | 82 ++++++++
 rtl/fetch_stage.sv | 134 +++++++++++++
 tb/tb_fetch_stage.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and widths for the instruction fetch stage.
package fetch_stage_pkg;

    localparam int unsigned ADDR_LINE = 32;
    localparam int unsigned D_SIZE    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    // Next sequential fetch address; wraps modulo 2^ADDR_LINE.
    function automatic logic [ADDR_LINE-1:0] pc_add(input logic [ADDR_LINE-1:0] pc,
                                                    input logic [ADDR_LINE-1:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect from execute,
// and the valid/ready instruction channel towards decode.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic                 imem_req;
    logic [ADDR_LINE-1:0] imem_addr;
    logic                 imem_ack;
    logic [D_SIZE-1:0]    imem_rdata;
    logic                 redirect;
    logic [ADDR_LINE-1:0] redirect_pc;
    logic                 ins_valid;
    logic                 ins_ready;
    logic [D_SIZE-1:0]    ins_data;
    logic [ADDR_LINE-1:0] ins_pc;

    // Fetch stage side
    modport master (
        output imem_req, imem_addr, ins_valid, ins_data, ins_pc,
        input  imem_ack, imem_rdata, redirect, redirect_pc, ins_ready
    );

    // Memory / execute / decode side
    modport slave (
        input  imem_req, imem_addr, ins_valid, ins_data, ins_pc,
        output imem_ack, imem_rdata, redirect, redirect_pc, ins_ready
    );

endinterface

// File: rtl/fetch_stage_fifo.sv
// Small synchronous FIFO with flush. The head entry and its valid flag are
// held in dedicated registers so decode sees clean registered outputs; a word
// pushed into an empty FIFO appears at the head on the following cycle.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       head_valid,
    output logic [WIDTH-1:0]           head_data
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_n_s, rd_ptr_n_s;
    logic [CNT_W-1:0] count_r, count_n_s;
    logic [WIDTH-1:0] head_r, head_n_s;
    logic             head_valid_r;
    logic             do_pop_s;

    // Pointer/count update and selection of the next head entry
    always_comb begin
        do_pop_s   = pop && (count_r != {CNT_W{1'b0}});
        wr_ptr_n_s = wr_ptr_r;
        rd_ptr_n_s = rd_ptr_r;
        count_n_s  = count_r;
        head_n_s   = head_r;
        if (flush) begin
            wr_ptr_n_s = {PTR_W{1'b0}};
            rd_ptr_n_s = {PTR_W{1'b0}};
            count_n_s  = {CNT_W{1'b0}};
        end else begin
            wr_ptr_n_s = wr_ptr_r + {{(PTR_W-1){1'b0}}, push};
            rd_ptr_n_s = rd_ptr_r + {{(PTR_W-1){1'b0}}, do_pop_s};
            count_n_s  = count_r + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, do_pop_s};
        end
        // The next head slot equals the write slot only when the FIFO drains to
        // just the incoming word; bypass it so head data is ready next cycle.
        if (count_n_s == {CNT_W{1'b0}}) begin
            head_n_s = head_r;
        end else if (push && (rd_ptr_n_s == wr_ptr_r)) begin
            head_n_s = push_data;
        end else begin
            head_n_s = mem_r[rd_ptr_n_s];
        end
    end

    // Storage, pointers and registered head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            head_r       <= {WIDTH{1'b0}};
            head_valid_r <= 1'b0;
        end else begin
            if (push && !flush) begin
                mem_r[wr_ptr_r] <= push_data;
            end
            wr_ptr_r     <= wr_ptr_n_s;
            rd_ptr_r     <= rd_ptr_n_s;
            count_r      <= count_n_s;
            head_r       <= head_n_s;
            head_valid_r <= (count_n_s != {CNT_W{1'b0}});
        end
    end

    assign count      = count_r;
    assign head_valid = head_valid_r;
    assign head_data  = head_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, one-outstanding request FSM towards
// instruction memory, and a small buffer feeding decode. A redirect flushes the
// buffer immediately; a request already on the bus is always completed, with
// its data discarded when it belongs to the old path.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [ADDR_LINE-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [ADDR_LINE-1:0] PC_STEP    = 32'h0000_0004,
    parameter int unsigned          FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          opr_en,
    fetch_stage_if.master bus
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH+1);
    localparam int unsigned ENT_W = ADDR_LINE + D_SIZE;

    fetch_state_t         state_r, state_n_s;
    logic [ADDR_LINE-1:0] pc_r, pc_n_s, pc_step_s;
    logic [ADDR_LINE-1:0] addr_r, addr_n_s;
    logic                 req_r, req_n_s;
    logic                 push_s, pop_s;
    logic [CNT_W-1:0]     count_s;
    logic [CNT_W:0]       fill_after_s;
    logic                 room_now_s, room_after_s;
    logic                 head_valid_s;
    logic [ENT_W-1:0]     head_s;

    assign pc_step_s    = pc_add(pc_r, PC_STEP);
    assign push_s       = (state_r == REQ) && bus.imem_ack && !bus.redirect;
    assign pop_s        = head_valid_s && bus.ins_ready;
    assign fill_after_s = {1'b0, count_s} + {{CNT_W{1'b0}}, push_s} - {{CNT_W{1'b0}}, pop_s};
    assign room_now_s   = ({1'b0, count_s} < (CNT_W+1)'(FIFO_DEPTH));
    assign room_after_s = (fill_after_s < (CNT_W+1)'(FIFO_DEPTH));

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push       (push_s),
        .push_data  ({addr_r, bus.imem_rdata}),
        .pop        (pop_s),
        .flush      (bus.redirect),
        .count      (count_s),
        .head_valid (head_valid_s),
        .head_data  (head_s)
    );

    // Next state, next PC and next request/address for the fetch FSM
    always_comb begin
        state_n_s = state_r;
        pc_n_s    = pc_r;
        addr_n_s  = addr_r;
        req_n_s   = req_r;
        case (state_r)
            IDLE: begin
                if (bus.redirect) begin
                    pc_n_s = bus.redirect_pc;
                end else if (opr_en && room_now_s) begin
                    state_n_s = REQ;
                    req_n_s   = 1'b1;
                    addr_n_s  = pc_r;
                end else begin
                    state_n_s = IDLE;
                end
            end
            REQ: begin
                if (bus.redirect) begin
                    pc_n_s = bus.redirect_pc;
                    if (bus.imem_ack) begin
                        state_n_s = IDLE;
                        req_n_s   = 1'b0;
                    end else begin
                        state_n_s = DROP;
                    end
                end else if (bus.imem_ack) begin
                    pc_n_s = pc_step_s;
                    if (opr_en && room_after_s) begin
                        state_n_s = REQ;
                        addr_n_s  = pc_step_s;
                    end else begin
                        state_n_s = IDLE;
                        req_n_s   = 1'b0;
                    end
                end else begin
                    state_n_s = REQ;
                end
            end
            DROP: begin
                if (bus.redirect) begin
                    pc_n_s = bus.redirect_pc;
                end else begin
                    pc_n_s = pc_r;
                end
                if (bus.imem_ack) begin
                    state_n_s = IDLE;
                    req_n_s   = 1'b0;
                end else begin
                    state_n_s = DROP;
                end
            end
            default: begin
                state_n_s = IDLE;
                req_n_s   = 1'b0;
            end
        endcase
    end

    // FSM state, PC and registered memory request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            pc_r    <= RESET_PC;
            addr_r  <= RESET_PC;
            req_r   <= 1'b0;
        end else begin
            state_r <= state_n_s;
            pc_r    <= pc_n_s;
            addr_r  <= addr_n_s;
            req_r   <= req_n_s;
        end
    end

    assign bus.imem_req  = req_r;
    assign bus.imem_addr = addr_r;
    assign bus.ins_valid = head_valid_s;
    assign bus.ins_data  = head_s[D_SIZE-1:0];
    assign bus.ins_pc    = head_s[ENT_W-1:D_SIZE];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a delayed-ack memory responder and a
// scoreboard of expected {pc, word} pairs checked at each decode handshake.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic opr_en;

    fetch_stage_if bus();

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .PC_STEP    (32'h0000_0004),
        .FIFO_DEPTH (2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .opr_en (opr_en),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    int ack_delay = 0;
    int ack_count = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_word(input logic [31:0] a);
        exp_q.push_back({a, word_of(a)});
    endtask

    task automatic wait_req(input string tag, input logic [31:0] a);
        for (int i = 0; i < 60; i++) begin
            if (bus.imem_req === 1'b1) break;
            step();
        end
        check({tag, "_req"}, {63'd0, bus.imem_req}, 64'd1);
        check({tag, "_addr"}, {32'd0, bus.imem_addr}, {32'd0, a});
    endtask

    task automatic wait_req_low(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (bus.imem_req === 1'b0) break;
            step();
        end
        check(tag, {63'd0, bus.imem_req}, 64'd0);
    endtask

    task automatic stop_on_ack(input string tag, input logic [31:0] a);
        bit found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.imem_ack === 1'b1 && bus.imem_addr === a) begin
                found = 1'b1;
                break;
            end
            step();
        end
        opr_en = 1'b0;
        check(tag, {63'd0, found}, 64'd1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // Memory responder: acks ack_delay cycles after a request appears and
    // checks that the address stays put while the request is waiting.
    initial begin
        int wait_cnt = 0;
        logic [31:0] held_addr = 32'h0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.imem_req === 1'b1) begin
                if (wait_cnt != 0) check("addr_stable", {32'd0, bus.imem_addr}, {32'd0, held_addr});
                held_addr = bus.imem_addr;
                if (wait_cnt >= ack_delay) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = word_of(bus.imem_addr);
                    wait_cnt       = 0;
                    ack_count++;
                end else begin
                    bus.imem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus.imem_ack = 1'b0;
                wait_cnt     = 0;
            end
        end
    end

    // Decode-side monitor: every accepted word must be the next expected one.
    // A handshake in the same cycle as a redirect is killed with the old path.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.ins_valid === 1'b1 && bus.ins_ready === 1'b1 && bus.redirect === 1'b0) begin
                check("word_expected", {63'd0, (exp_q.size() > 0)}, 64'd1);
                if (exp_q.size() > 0) begin
                    check("deliver", {bus.ins_pc, bus.ins_data}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int base;
        reset           = 1'b0;
        opr_en          = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.ins_ready   = 1'b0;
        repeat (3) step();

        // 1: reset values, then reset asserted mid-request
        check("rst_req",   {63'd0, bus.imem_req},  64'd0);
        check("rst_valid", {63'd0, bus.ins_valid}, 64'd0);
        check("rst_addr",  {32'd0, bus.imem_addr}, 64'd0);
        check("rst_data",  {32'd0, bus.ins_data},  64'd0);
        check("rst_pc",    {32'd0, bus.ins_pc},    64'd0);
        reset     = 1'b1;
        ack_delay = 3;
        opr_en    = 1'b1;
        wait_req("t1_first", 32'h0);
        step();
        reset = 1'b0;
        #1;
        check("t1_midreq_req",   {63'd0, bus.imem_req},  64'd0);
        check("t1_midreq_valid", {63'd0, bus.ins_valid}, 64'd0);
        check("t1_midreq_addr",  {32'd0, bus.imem_addr}, 64'd0);
        opr_en = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();

        // 2: streaming with ack every cycle and decode always ready
        expect_word(32'h0);
        expect_word(32'h4);
        expect_word(32'h8);
        expect_word(32'hC);
        bus.ins_ready = 1'b1;
        ack_delay     = 0;
        opr_en        = 1'b1;
        wait_req("t2_first", 32'h0);
        step();
        check("t2_lat_valid", {63'd0, bus.ins_valid}, 64'd1);
        check("t2_lat_word", {bus.ins_pc, bus.ins_data}, {32'h0, word_of(32'h0)});
        stop_on_ack("t2_stop", 32'hC);
        drain("t2_drain");
        repeat (3) step();
        check("t2_idle", {63'd0, bus.imem_req}, 64'd0);

        // 3: backpressure fills the buffer, release resumes at 0x8
        bus.ins_ready   = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0;
        step();
        bus.redirect = 1'b0;
        base   = ack_count;
        opr_en = 1'b1;
        repeat (10) step();
        check("t3_buffered", 64'(ack_count - base), 64'd2);
        check("t3_req_low", {63'd0, bus.imem_req}, 64'd0);
        check("t3_valid", {63'd0, bus.ins_valid}, 64'd1);
        check("t3_head_pc", {32'd0, bus.ins_pc}, 64'd0);
        expect_word(32'h0);
        expect_word(32'h4);
        expect_word(32'h8);
        expect_word(32'hC);
        bus.ins_ready = 1'b1;
        wait_req("t3_resume", 32'h8);
        stop_on_ack("t3_stop", 32'hC);
        drain("t3_drain");

        // 4: redirect while a slow request is outstanding
        ack_delay = 3;
        opr_en    = 1'b1;
        wait_req("t4_first", 32'h10);
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        step();
        bus.redirect = 1'b0;
        check("t4_drop_req", {63'd0, bus.imem_req}, 64'd1);
        check("t4_drop_addr", {32'd0, bus.imem_addr}, 64'h10);
        expect_word(32'h100);
        wait_req_low("t4_req_done");
        wait_req("t4_new", 32'h100);
        stop_on_ack("t4_stop", 32'h100);
        drain("t4_drain");

        // 5: redirect coincident with an ack and with a decode pop
        ack_delay = 0;
        opr_en    = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (bus.imem_ack === 1'b1 && bus.ins_valid === 1'b1) break;
            step();
        end
        check("t5_coincide", {63'd0, (bus.imem_ack === 1'b1 && bus.ins_valid === 1'b1)}, 64'd1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        step();
        bus.redirect = 1'b0;
        check("t5_flushed", {63'd0, bus.ins_valid}, 64'd0);
        check("t5_req_low", {63'd0, bus.imem_req}, 64'd0);
        expect_word(32'h200);
        wait_req("t5_new", 32'h200);
        stop_on_ack("t5_stop", 32'h200);
        drain("t5_drain");

        // 6: opr_en dropped mid-request, then PC wrap
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        step();
        bus.redirect = 1'b0;
        ack_delay    = 2;
        expect_word(32'hFFFF_FFFC);
        opr_en = 1'b1;
        wait_req("t6_top", 32'hFFFF_FFFC);
        opr_en = 1'b0;
        drain("t6_drain");
        base = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.imem_req === 1'b1) base++;
        end
        check("t6_no_more_req", 64'(base), 64'd0);
        ack_delay = 0;
        expect_word(32'h0);
        opr_en = 1'b1;
        wait_req("t6_wrap", 32'h0);
        stop_on_ack("t6_stop", 32'h0);
        drain("t6_wrap_drain");

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
